nibble_feeder: RTL and testbench
================================

NIBBLE_FEEDER -- requirements
Module: nibble_feeder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, FIFO entry count, power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_data, input, 4 bits: nibble offered by the producer.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: FIFO can accept.
REQ-007 The block SHALL have port auto_en, input, 1 bit: enable the incrementing-pattern generator when the FIFO is empty.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream register stage accepts d this cycle.
REQ-009 The block SHALL have port d, output, 4 bits: registered nibble driving the downstream register stage's d input.
REQ-010 The block SHALL have port d_valid, output, 1 bit: d holds a valid nibble.
REQ-011 The block SHALL have port bit2, output, 1 bit: combinational copy of d[2].
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy, registered.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 The FIFO SHALL hold DEPTH 4-bit entries; read and write pointers wrap modulo DEPTH; count range is 0..DEPTH.
REQ-015 in_ready SHALL equal (count < DEPTH) AND rst_n.
REQ-016 A push SHALL occur at a posedge where in_valid && in_ready; in_data is written at the write pointer, which then increments.
REQ-017 The output register SHALL load when !d_valid || out_ready ("load slot").
REQ-018 In a load slot with count > 0: d <= FIFO head, d_valid <= 1, read pointer increments (pop).
REQ-019 In a load slot with count == 0 and auto_en == 1: d <= auto_val, d_valid <= 1, auto_val <= auto_val + 1 mod 16.
REQ-020 In a load slot with count == 0 and auto_en == 0: d_valid <= 0, d holds its value.
REQ-021 Outside a load slot, d and d_valid SHALL hold, and auto_val SHALL hold.
REQ-022 FIFO data SHALL take priority over auto_val; auto_val SHALL not advance on a cycle that pops the FIFO.
REQ-023 There SHALL be no bypass: a nibble pushed at edge k is at the earliest on d after edge k+1.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; push only gives +1, pop only gives -1.
REQ-025 With count == DEPTH and a pop in the same cycle, in_ready SHALL still be 0 that cycle; no push occurs.
REQ-026 ovf SHALL set at any posedge where in_valid && !in_ready && rst_n, and clear only on reset.
REQ-027 bit2 SHALL be d[2] at all times, including while d_valid is 0.

Reset
REQ-028 At a posedge with rst_n == 0: count = 0, both pointers = 0, d = 0, d_valid = 0, auto_val = 0, ovf = 0; FIFO contents are discarded.
REQ-029 Reset SHALL override any simultaneous push or load, including a reset asserted mid-operation.
REQ-030 in_ready SHALL be 0 while rst_n is low.
REQ-031 FIFO storage array contents need not be reset.

Verification
REQ-032 Scenario auto pattern: reset, then auto_en=1, out_ready=1, in_valid=0 -> d = 0,1,2,...,F,0 on consecutive cycles; d_valid=1 from the first edge after reset release.
REQ-033 Scenario fill/overflow: DEPTH=4, auto_en=0, out_ready=0; push 5,3,7,9,2 back-to-back, then in_valid=1 with 6 -> d=5, d_valid=1, count=4, in_ready=0, 6 dropped, ovf=1.
REQ-034 Scenario drain: from REQ-033, out_ready=1, in_valid=0 -> d = 3,7,9,2 on successive cycles, then d_valid=0, d holds 2, count=0, ovf stays 1.
REQ-035 Scenario priority: auto_en=1, out_ready=1, auto stream at 4; push A once -> d sequence 4, A, 5 (auto_val does not advance on the A cycle).
REQ-036 Scenario mid-operation reset: count=3, d_valid=1; rst_n=0 for one edge -> count=0, d=0, d_valid=0, ovf=0, in_ready=0 during reset; the old contents never appear.
REQ-037 Scenario bit2: d=4 -> bit2=1; d=B -> bit2=0; d=C with out_ready=0 held -> bit2 stays 1.

Source files
------------

// File: rtl/nibble_feeder.sv
// Small nibble FIFO feeding a registered output stage. When the FIFO is empty,
// an optional incrementing 4-bit pattern generator can fill the output instead.
module nibble_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     auto_en,
  input  logic                     out_ready,
  output logic [3:0]               d,
  output logic                     d_valid,
  output logic                     bit2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_d;
  logic          r_d_valid;
  logic [3:0]    r_auto_val;
  logic          r_ovf;

  logic w_in_ready;
  logic w_push;
  logic w_load;
  logic w_pop;

  // Readiness looks only at the registered count, so a pop cannot free a slot
  // for a push in the same cycle; the FIFO never bypasses to the output.
  assign w_in_ready = (r_count != FULL) && rst_n;
  assign w_push     = in_valid && w_in_ready;
  assign w_load     = !r_d_valid || out_ready;
  assign w_pop      = w_load && (r_count != '0);

  // NOTE: the storage array has no reset; clearing pointers and count makes old
  // entries unreachable, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // NOTE: every state register uses non-blocking assignments so that all reads
  // in this block see pre-edge values, matching the hardware's parallel update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_d        <= '0;
      r_d_valid  <= 1'b0;
      r_auto_val <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (in_valid && !w_in_ready) begin
        r_ovf <= 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_load) begin
        if (w_pop) begin
          r_d       <= r_mem[r_rd_ptr];
          r_d_valid <= 1'b1;
          r_rd_ptr  <= r_rd_ptr + AW'(1);
        end else if (auto_en) begin
          r_d        <= r_auto_val;
          r_d_valid  <= 1'b1;
          r_auto_val <= r_auto_val + 4'd1;
        end else begin
          r_d_valid <= 1'b0;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign d        = r_d;
  assign d_valid  = r_d_valid;
  assign bit2     = r_d[2];
  assign count    = r_count;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_nibble_feeder.sv
// Bench for nibble_feeder: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nibble_feeder;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [3:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          auto_en;
  logic          out_ready;
  logic [3:0]    d;
  logic          d_valid;
  logic          bit2;
  logic [CW-1:0] count;
  logic          ovf;

  int n_tests = 0;
  int n_fails = 0;

  nibble_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .auto_en   (auto_en),
    .out_ready (out_ready),
    .d         (d),
    .d_valid   (d_valid),
    .bit2      (bit2),
    .count     (count),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, output stage and pattern counter as plain values.
  int         m_q[$];
  logic [3:0] m_d;
  logic       m_dv;
  int         m_auto;
  logic       m_ovf;
  logic       m_known = 1'b0;

  always @(posedge clk) begin
    bit can_push;
    if (!rst_n) begin
      m_q.delete();
      m_d     = 4'd0;
      m_dv    = 1'b0;
      m_auto  = 0;
      m_ovf   = 1'b0;
      m_known = 1'b1;
    end else begin
      can_push = (m_q.size() < DEPTH);
      if (in_valid && !can_push) m_ovf = 1'b1;
      if (!m_dv || out_ready) begin
        if (m_q.size() > 0) begin
          m_d  = 4'(m_q.pop_front());
          m_dv = 1'b1;
        end else if (auto_en) begin
          m_d    = 4'(m_auto);
          m_auto = (m_auto + 1) % 16;
          m_dv   = 1'b1;
        end else begin
          m_dv = 1'b0;
        end
      end
      if (in_valid && can_push) m_q.push_back(int'(in_data));
    end
    #1;
    if (m_known) begin
      check("cmp_count",    int'(count),    m_q.size());
      check("cmp_d",        int'(d),        int'(m_d));
      check("cmp_d_valid",  int'(d_valid),  int'(m_dv));
      check("cmp_bit2",     int'(bit2),     int'(m_d[2]));
      check("cmp_ovf",      int'(ovf),      int'(m_ovf));
      check("cmp_in_ready", int'(in_ready), int'((m_q.size() < DEPTH) && rst_n));
    end
  end

  // Called at a negedge: apply inputs, let one posedge pass, return at the next negedge.
  task automatic drive(input logic rn, input logic iv, input logic [3:0] id,
                       input logic ae, input logic ordy);
    rst_n     = rn;
    in_valid  = iv;
    in_data   = id;
    auto_en   = ae;
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; auto_en = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("rst_count",    int'(count),    0);
    check("rst_d",        int'(d),        0);
    check("rst_d_valid",  int'(d_valid),  0);
    check("rst_ovf",      int'(ovf),      0);
    check("rst_in_ready", int'(in_ready), 0);

    // Auto pattern 0..F,0
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 1, 1);
      check("auto_d_valid", int'(d_valid), 1);
      check("auto_d",       int'(d),       i % 16);
    end

    // Fill and overflow
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 4'h5, 0, 0);
    drive(1, 1, 4'h3, 0, 0);
    drive(1, 1, 4'h7, 0, 0);
    drive(1, 1, 4'h9, 0, 0);
    drive(1, 1, 4'h2, 0, 0);
    check("fill_ovf_before", int'(ovf), 0);
    drive(1, 1, 4'h6, 0, 0);
    check("fill_d",        int'(d),        5);
    check("fill_d_valid",  int'(d_valid),  1);
    check("fill_count",    int'(count),    4);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_ovf",      int'(ovf),      1);

    // Drain
    begin
      int exp_seq[4] = '{3, 7, 9, 2};
      for (int i = 0; i < 4; i++) begin
        drive(1, 0, 0, 0, 1);
        check("drain_d", int'(d), exp_seq[i]);
        check("drain_count", int'(count), 3 - i);
      end
    end
    drive(1, 0, 0, 0, 1);
    check("drain_d_valid", int'(d_valid), 0);
    check("drain_d_hold",  int'(d),       2);
    check("drain_count0",  int'(count),   0);
    check("drain_ovf",     int'(ovf),     1);

    // Priority: FIFO entry wins over the pattern, which does not advance that cycle
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 1);
    check("prio_pre", int'(d), 3);
    drive(1, 1, 4'hA, 1, 1);
    check("prio_4", int'(d), 4);
    drive(1, 0, 0, 1, 1);
    check("prio_A", int'(d), 10);
    drive(1, 0, 0, 1, 1);
    check("prio_5", int'(d), 5);

    // Mid-operation reset
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 4'h1, 0, 0);
    drive(1, 1, 4'h2, 0, 0);
    drive(1, 1, 4'h3, 0, 0);
    drive(1, 1, 4'h4, 0, 0);
    check("mid_count_pre", int'(count),   3);
    check("mid_dv_pre",    int'(d_valid), 1);
    drive(0, 1, 4'h5, 0, 1);
    check("mid_count",    int'(count),    0);
    check("mid_d",        int'(d),        0);
    check("mid_d_valid",  int'(d_valid),  0);
    check("mid_ovf",      int'(ovf),      0);
    check("mid_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1);
      check("mid_no_stale", int'(d_valid), 0);
    end

    // bit2 tracks d
    drive(1, 1, 4'h4, 0, 1);
    drive(1, 1, 4'hB, 0, 1);
    check("bit2_4", int'(bit2), 1);
    drive(1, 1, 4'hC, 0, 1);
    check("bit2_B", int'(bit2), 0);
    drive(1, 0, 0, 0, 1);
    check("bit2_C", int'(bit2), 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      check("bit2_hold", int'(bit2), 1);
      check("bit2_hold_d", int'(d), 12);
    end

    // Randomized traffic with varying bias
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        logic rn, iv, ae, ordy;
        rn   = ($urandom_range(0, 59) != 0);
        iv   = ($urandom_range(0, 3) < 3 - (ph % 3));
        ae   = ($urandom_range(0, 1) == 1);
        ordy = ($urandom_range(0, 3) <= ph);
        drive(rn, iv, 4'($urandom_range(0, 15)), ae, ordy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
